floor_request_scheduler: RTL and testbench
==========================================

Name: floor_request_scheduler

Overview:
Request-handling stage directly upstream of the elevator controller. It latches per-floor call buttons into a pending mask. It picks the next target floor using a direction-preserving (SCAN) policy and drives the controller's `in` (target) and `stop` inputs. It also times the door dwell at each served floor and clears a request once it is served.

Parameters:
DWELL_CYCLES, 8, number of cycles `stop` is held high at a served floor (legal range 1..255).
DWELL_W, 8, width of the dwell down-counter.

Ports:
clk  input  1  system clock, all logic on the rising edge
rst  input  1  synchronous, active-high reset
call_btn  input  4  level call request, bit i = floor i
cancel_all  input  1  clears every pending request in the same cycle
cur_floor  input  2  floor currently reported by the elevator controller
target  output  2  registered target floor, feeds the controller's `in`
stop  output  1  registered hold/dwell, feeds the controller's `stop`
pending  output  4  registered pending-request mask
dir_up  output  1  current sweep direction (1 = up)
busy  output  1  high whenever the state is not IDLE

Behaviour:
- Reset (synchronous, rst=1 at a rising edge): state=IDLE, pending=0000, target=00, stop=1, dir_up=1, busy=0, dwell counter=0. Reset wins over every other input. A reset mid-MOVE or mid-DWELL aborts the operation and drops all requests.
- Pending update, every cycle: pending <= (pending | call_btn) & ~clear_mask.
  - clear_mask = 1111 when cancel_all=1.
  - Otherwise clear_mask = onehot(cur_floor) in the DWELL-entry cycle and during all of DWELL.
  - Otherwise clear_mask = 0000.
  - Clear always wins over set, so a call at the floor being served is absorbed.
- Target selection rule (SCAN), evaluated on the mask m = pending | call_btn:
  - If dir_up=1 and m has a bit above cur_floor: select the nearest such floor.
  - Else if m has a bit below cur_floor: select the nearest below and set dir_up=0.
  - Else if m has a bit above cur_floor: select the nearest above and set dir_up=1.
- State IDLE (stop=1, target=cur_floor):
  - m==0: stay in IDLE.
  - m[cur_floor]=1: go to DWELL. Load counter with DWELL_CYCLES-1; the bit is cleared.
  - Else: apply the SCAN rule, register target and dir_up, go to MOVE, stop<=0.
  - A decision takes 1 cycle: a call in cycle N gives target/stop updated at edge N+1.
- State MOVE (stop=0):
  - target is committed and is only retargeted when a newly pending floor lies strictly between cur_floor and target in the direction of travel. It then becomes the nearer floor.
  - When cur_floor==target: go to DWELL, stop<=1, load counter, clear pending[target].
  - cancel_all in MOVE clears pending but does not abort. The committed target is still reached and dwelled.
- State DWELL (stop=1, target held):
  - The counter decrements each cycle.
  - When the counter reaches 0: go to IDLE, where the next decision is made 1 cycle later.
  - stop is high for exactly DWELL_CYCLES cycles in DWELL, plus the IDLE cycle if nothing is pending.
- Boundaries:
  - Floor 3 reached going up with nothing above: direction reverses only via the SCAN rule in IDLE.
  - Floor 0 behaves symmetrically.
  - Simultaneous calls above and below in IDLE: the current dir_up decides.
  - cur_floor jumps by more than one floor (controller fault): no special handling; arrival is an equality compare only.
- All outputs are registered. No combinational path exists from inputs to outputs.

Test Plan:
- Reset, then idle: rst=1 for 2 cycles, then all inputs 0 -> pending=0000, stop=1, target=00, busy=0, dir_up=1 held indefinitely.
- Single call: cur_floor=0, pulse call_btn=1000 for 1 cycle -> next edge target=11, stop=0, dir_up=1. Step cur_floor 1,2,3 -> at 3: stop=1, pending=0000, stop high for 8 cycles, then IDLE.
- On-the-way pickup: cur_floor=0, target=3 in MOVE, call_btn=0100 while cur_floor=1 -> target becomes 10. Dwell at 2 -> then target=11 is resumed.
- Direction priority: in IDLE at floor 1 with dir_up=1, pending=1001 -> target=11. After serving floor 3 -> target=00, dir_up=0.
- Call at the current floor during dwell: DWELL at floor 2, call_btn=0100 held -> pending[2] stays 0, dwell length is unchanged (8 cycles).
- cancel_all and reset mid-operation: in MOVE toward 3 with pending=1010, cancel_all=1 -> pending=0000 and the committed target 3 is still served. Separately, rst=1 mid-DWELL -> next edge IDLE, stop=1, target=00, pending=0000.

Source files
------------

// File: rtl/floor_request_scheduler.sv
// Request scheduler that sits in front of the elevator controller: it latches call
// buttons, chooses SCAN targets, and times the door dwell at each served floor.
module floor_request_scheduler #(
  parameter int DWELL_CYCLES = 8,
  parameter int DWELL_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] call_btn,
  input  logic       cancel_all,
  input  logic [1:0] cur_floor,
  output logic [1:0] target,
  output logic       stop,
  output logic [3:0] pending,
  output logic       dir_up,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, MOVE, DWELL} state_t;

  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES - 1);

  state_t             state, state_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic [1:0]         target_n;
  logic               stop_n, dir_n;
  logic [3:0]         pending_n, clear, live, here;
  logic [2:0]         up, dn;

  // {found, floor} of the nearest requested floor strictly above f
  function automatic logic [2:0] nearest_above(input logic [3:0] m, input logic [1:0] f);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 3; i >= 0; i--)
      if (i > int'(f) && m[i]) res = {1'b1, 2'(i)};
    return res;
  endfunction

  // {found, floor} of the nearest requested floor strictly below f
  function automatic logic [2:0] nearest_below(input logic [3:0] m, input logic [1:0] f);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 0; i <= 3; i++)
      if (i < int'(f) && m[i]) res = {1'b1, 2'(i)};
    return res;
  endfunction

  // cancel_all suppresses every request, including ones arriving this cycle
  assign live = cancel_all ? 4'b0000 : (pending | call_btn);
  assign here = 4'b0001 << cur_floor;
  assign up   = nearest_above(live, cur_floor);
  assign dn   = nearest_below(live, cur_floor);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    target_n = target;
    stop_n   = stop;
    dir_n    = dir_up;
    clear    = 4'b0000;
    case (state)
      IDLE: begin
        target_n = cur_floor;
        stop_n   = 1'b1;
        if (live[cur_floor]) begin
          state_n = DWELL;
          cnt_n   = DWELL_LOAD;
          clear   = here;
        end else if (live != 4'b0000) begin
          state_n = MOVE;
          stop_n  = 1'b0;
          if (dir_up && up[2]) begin
            target_n = up[1:0];
          end else if (dn[2]) begin
            target_n = dn[1:0];
            dir_n    = 1'b0;
          end else begin
            target_n = up[1:0];
            dir_n    = 1'b1;
          end
        end
      end
      MOVE: begin
        if (cur_floor == target) begin
          state_n = DWELL;
          stop_n  = 1'b1;
          cnt_n   = DWELL_LOAD;
          clear   = here;
        end else if (dir_up && up[2] && up[1:0] < target) begin
          target_n = up[1:0];
        end else if (!dir_up && dn[2] && dn[1:0] > target) begin
          target_n = dn[1:0];
        end
      end
      DWELL: begin
        clear = here;
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (cancel_all) clear = 4'b1111;
    pending_n = (pending | call_btn) & ~clear;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      target  <= 2'b00;
      stop    <= 1'b1;
      dir_up  <= 1'b1;
      pending <= 4'b0000;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      target  <= target_n;
      stop    <= stop_n;
      dir_up  <= dir_n;
      pending <= pending_n;
      busy    <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Directed bench for floor_request_scheduler: walks the elevator through pickups,
// direction reversal, dwell absorption, cancel and reset, checking outputs each step.
module tb_floor_request_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] call_btn;
  logic       cancel_all;
  logic [1:0] cur_floor;
  logic [1:0] target;
  logic       stop;
  logic [3:0] pending;
  logic       dir_up;
  logic       busy;

  int passes = 0;
  int total  = 0;

  floor_request_scheduler #(.DWELL_CYCLES(8), .DWELL_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .call_btn   (call_btn),
    .cancel_all (cancel_all),
    .cur_floor  (cur_floor),
    .target     (target),
    .stop       (stop),
    .pending    (pending),
    .dir_up     (dir_up),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; call_btn = 4'b0000; cancel_all = 1'b0; cur_floor = 2'd0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_pending", 8'(pending), 8'h0);
    chk("rst_stop",    8'(stop),    8'h1);
    chk("rst_target",  8'(target),  8'h0);
    chk("rst_busy",    8'(busy),    8'h0);
    chk("rst_dir",     8'(dir_up),  8'h1);
    tick(); tick(); tick();
    chk("idle_stop", 8'(stop), 8'h1);
    chk("idle_busy", 8'(busy), 8'h0);

    // single call to floor 3 from floor 0
    call_btn = 4'b1000;
    tick();
    call_btn = 4'b0000;
    chk("s_target",  8'(target),  8'h3);
    chk("s_stop",    8'(stop),    8'h0);
    chk("s_dir",     8'(dir_up),  8'h1);
    chk("s_pending", 8'(pending), 8'h8);
    chk("s_busy",    8'(busy),    8'h1);
    cur_floor = 2'd1; tick();
    cur_floor = 2'd2; tick();
    cur_floor = 2'd3; tick();
    chk("s_arr_stop",    8'(stop),    8'h1);
    chk("s_arr_pending", 8'(pending), 8'h0);
    repeat (7) tick();
    chk("s_dwell_last_busy", 8'(busy), 8'h1);
    chk("s_dwell_last_stop", 8'(stop), 8'h1);
    tick();
    chk("s_idle_busy",   8'(busy),   8'h0);
    chk("s_idle_target", 8'(target), 8'h3);

    // on-the-way pickup at floor 2
    cur_floor = 2'd0; tick();
    call_btn = 4'b1000; tick();
    call_btn = 4'b0100; cur_floor = 2'd1; tick();
    call_btn = 4'b0000;
    chk("p_retarget", 8'(target),  8'h2);
    chk("p_pending",  8'(pending), 8'hC);
    cur_floor = 2'd2; tick();
    chk("p_arr_pending", 8'(pending), 8'h8);
    chk("p_arr_stop",    8'(stop),    8'h1);
    repeat (8) tick();
    chk("p_idle_busy", 8'(busy), 8'h0);
    tick();
    chk("p_resume_target", 8'(target), 8'h3);
    chk("p_resume_stop",   8'(stop),   8'h0);
    cur_floor = 2'd3; tick();
    chk("p_arr3_pending", 8'(pending), 8'h0);
    repeat (8) tick();

    // direction priority: calls above and below at floor 1, going up
    cur_floor = 2'd1; call_btn = 4'b1001; tick();
    call_btn = 4'b0000;
    chk("d_target",  8'(target),  8'h3);
    chk("d_dir",     8'(dir_up),  8'h1);
    chk("d_pending", 8'(pending), 8'h9);
    cur_floor = 2'd2; tick();
    cur_floor = 2'd3; tick();
    chk("d_arr_pending", 8'(pending), 8'h1);
    repeat (8) tick();
    tick();
    chk("d_rev_target", 8'(target), 8'h0);
    chk("d_rev_dir",    8'(dir_up), 8'h0);
    chk("d_rev_stop",   8'(stop),   8'h0);
    cur_floor = 2'd2; tick();
    cur_floor = 2'd1; tick();
    cur_floor = 2'd0; tick();
    chk("d_arr0_stop", 8'(stop), 8'h1);
    repeat (8) tick();

    // call held at the floor being served during dwell
    call_btn = 4'b0100; tick();
    call_btn = 4'b0000;
    chk("w_target", 8'(target), 8'h2);
    chk("w_dir",    8'(dir_up), 8'h1);
    cur_floor = 2'd1; tick();
    cur_floor = 2'd2; call_btn = 4'b0100; tick();
    chk("w_arr_pending", 8'(pending), 8'h0);
    repeat (7) tick();
    chk("w_mid_pending", 8'(pending), 8'h0);
    chk("w_mid_busy",    8'(busy),    8'h1);
    tick();
    chk("w_end_busy",    8'(busy),    8'h0);
    chk("w_end_pending", 8'(pending), 8'h0);
    call_btn = 4'b0000; tick();
    chk("w_idle_busy", 8'(busy), 8'h0);
    chk("w_idle_stop", 8'(stop), 8'h1);

    // cancel_all while moving to 3 with 1010 pending
    cur_floor = 2'd0; tick();
    call_btn = 4'b1000; tick();
    call_btn = 4'b0010; cur_floor = 2'd2; tick();
    call_btn = 4'b0000;
    chk("c_pending", 8'(pending), 8'hA);
    chk("c_target",  8'(target),  8'h3);
    cancel_all = 1'b1; tick();
    cancel_all = 1'b0;
    chk("c_cleared", 8'(pending), 8'h0);
    chk("c_target2", 8'(target),  8'h3);
    chk("c_moving",  8'(stop),    8'h0);
    chk("c_busy",    8'(busy),    8'h1);
    cur_floor = 2'd3; tick();
    chk("c_arr_stop", 8'(stop), 8'h1);
    chk("c_arr_busy", 8'(busy), 8'h1);

    // reset mid-dwell with a call present
    tick(); tick();
    rst = 1'b1; call_btn = 4'b0100; tick();
    rst = 1'b0; call_btn = 4'b0000;
    chk("r_busy",    8'(busy),    8'h0);
    chk("r_stop",    8'(stop),    8'h1);
    chk("r_target",  8'(target),  8'h0);
    chk("r_pending", 8'(pending), 8'h0);
    chk("r_dir",     8'(dir_up),  8'h1);
    cur_floor = 2'd0; tick();
    chk("r_after_busy", 8'(busy), 8'h0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
